// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Ceiling log2, used to size the bit counter from WIDTH.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder used for the per-cycle bit sum.
module fa_bit (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder step per clock with a valid/ready handshake.
// Optional overflow output ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             co,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int unsigned CntW = clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("serial_adder: WIDTH must be in 2..16");
    end

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic fa_s;
    logic fa_co;
    logic accept;
    logic consume;
    logic last_bit;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign last_bit  = (cnt_q == LastBit);

    fa_bit u_fa (
        .s  (fa_s),
        .co (fa_co),
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)   state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  if (consume)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Sum bits enter at the MSB so after WIDTH steps s_sh_q holds the sum in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= ci;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            s_sh_q  <= {fa_s, s_sh_q[WIDTH-1:1]};
            carry_q <= fa_co;
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            cnt_q   <= cnt_q + CntW'(1);
        end
    end

    assign s  = s_sh_q;
    assign co = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Carry into the MSB is carry_q while the last bit is being processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && last_bit) begin
            ovf_q <= carry_q ^ fa_co;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic reference model plus directed scenarios.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int n_chk  = 0;
    int n_pass = 0;

    serial_adder #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .s         (s),
        .co        (co),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Signed overflow of x+y+c, computed on integers.
    function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, r;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        r  = sx + sy + int'(c);
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Reference model: an accepted op yields its sum exactly W edges later, held until taken.
    logic         m_busy = 1'b0;
    int           m_cyc  = 0;
    int           m_acc  = 0;
    logic [W:0]   m_sum  = '0;
    logic         m_ovf  = 1'b0;
    logic         m_rdy;
    logic         m_ov;

    assign m_rdy = !m_busy;
    assign m_ov  = m_busy && ((m_cyc - m_acc) >= W);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_ov && out_ready) begin
                m_busy <= 1'b0;
            end else if (m_rdy && in_valid) begin
                m_busy <= 1'b1;
                m_acc  <= m_cyc + 1;
                m_sum  <= {1'b0, a} + {1'b0, b} + (W+1)'(ci);
                m_ovf  <= ovf_of(a, b, ci);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_in_ready", 32'(in_ready), 32'(m_rdy));
        check("cyc_out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("cyc_s", 32'(s), 32'(m_sum[W-1:0]));
            check("cyc_co", 32'(co), 32'(m_sum[W]));
`ifdef SERIAL_ADDER_OVF_EN
            check("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output logic [W-1:0] rs, output logic rco, output logic rov,
                         output int lat);
        int waitn;
        waitn = 0;
        @(negedge clk);
        while (!in_ready && waitn < 50) begin
            @(negedge clk);
            waitn++;
        end
        check("op_in_ready_wait", 32'(in_ready), 1);
        a        = xa;
        b        = xb;
        ci       = xc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        ci       = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rs  = s;
        rco = co;
        rov = ovf;
    endtask

    logic [W-1:0] rs;
    logic         rco;
    logic         rov;
    int           lat;
    int           idx[$];

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_s", 32'(s), 0);
        check("rst_co", 32'(co), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(4'h3, 4'h5, 1'b0, rs, rco, rov, lat);
        check("op35_latency", lat, W);
        check("op35_s", 32'(rs), 32'h8);
        check("op35_co", 32'(rco), 0);
        check("model_35", 32'(m_sum), 32'h08);

        do_op(4'hF, 4'h1, 1'b0, rs, rco, rov, lat);
        check("opF1_s", 32'(rs), 32'h0);
        check("opF1_co", 32'(rco), 1);
        check("model_F1", 32'(m_sum), 32'h10);

        do_op(4'hF, 4'hF, 1'b1, rs, rco, rov, lat);
        check("opFF1_s", 32'(rs), 32'hF);
        check("opFF1_co", 32'(rco), 1);
        check("model_FF1", 32'(m_sum), 32'h1F);

        // Backpressure: result must hold in DONE while out_ready is low.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        do_op(4'h2, 4'h3, 1'b1, rs, rco, rov, lat);
        check("bp_latency", lat, W);
        check("bp_s", 32'(rs), 32'h6);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_s", 32'(s), 32'h6);
            check("bp_hold_co", 32'(co), 0);
            check("bp_hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_in_ready", 32'(in_ready), 1);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a        = 4'h1;
        b        = 4'h1;
        ci       = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_s", 32'(s), 0);
        check("midrst_co", 32'(co), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'h2, 4'h2, 1'b0, rs, rco, rov, lat);
        check("postrst_s", 32'(rs), 32'h4);
        check("postrst_co", 32'(rco), 0);

        // in_valid held high with operands changing every cycle.
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) idx.push_back(i);
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
        end
        in_valid = 1'b0;
        check("b2b_count", 32'(idx.size() >= 3), 1);
        for (int k = 1; k < idx.size(); k++) begin
            check("b2b_spacing", idx[k] - idx[k-1], W + 2);
        end

`ifdef SERIAL_ADDER_OVF_EN
        repeat (2) @(posedge clk);
        do_op(4'h7, 4'h1, 1'b0, rs, rco, rov, lat);
        check("ovf71_s", 32'(rs), 32'h8);
        check("ovf71_co", 32'(rco), 0);
        check("ovf71_ovf", 32'(rov), 1);
        do_op(4'hF, 4'h1, 1'b0, rs, rco, rov, lat);
        check("ovfF1_ovf", 32'(rov), 0);
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            ci        = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2 * W + 4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
